// File: rtl/tile_board_shuffler.sv
// Builds a shuffled 10-tile board (five colour pairs) via fill + Fisher-Yates over a free-running LFSR.
// Optional colour-count self-check after the shuffle is enabled by defining TILE_SHUFFLE_CHECK_EN.
module tile_board_shuffler #(
    parameter int unsigned NUM_TILES = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [3:0]  rd_idx,
    output logic [10:0] rd_code,
    output logic        err
);

    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [3:0]  LAST_IDX  = 4'(NUM_TILES - 1);
    localparam logic [4:0]  TILES_5B  = 5'(NUM_TILES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_SHUFFLE = 3'd2,
`ifdef TILE_SHUFFLE_CHECK_EN
        S_CHECK   = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

`ifdef TILE_SHUFFLE_CHECK_EN
    localparam state_t SHUFFLE_EXIT = S_CHECK;
`else
    localparam state_t SHUFFLE_EXIT = S_DONE;
`endif

    function automatic logic [5:0] default_colour(input logic [3:0] k);
        case (k)
            4'd0:    default_colour = 6'd1;
            4'd1:    default_colour = 6'd2;
            4'd2:    default_colour = 6'd3;
            4'd3:    default_colour = 6'd4;
            4'd4:    default_colour = 6'd2;
            4'd5:    default_colour = 6'd4;
            4'd6:    default_colour = 6'd3;
            4'd7:    default_colour = 6'd1;
            4'd8:    default_colour = 6'd5;
            4'd9:    default_colour = 6'd5;
            default: default_colour = {3'b000, k[3:1]} + 6'd1;
        endcase
    endfunction

    // Smallest all-ones mask covering 0..i, so rejection sampling stays unbiased.
    function automatic logic [3:0] draw_mask(input logic [3:0] i);
        if (i <= 4'd1)      draw_mask = 4'd1;
        else if (i <= 4'd3) draw_mask = 4'd3;
        else if (i <= 4'd7) draw_mask = 4'd7;
        else                draw_mask = 4'd15;
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_next;
    logic [15:0] r_lfsr;
    logic [5:0]  r_tile      [NUM_TILES];
    logic [5:0]  w_tile_next [NUM_TILES];
    logic [3:0]  w_draw;
    logic        w_busy_next;
    logic        r_busy;
    logic        r_done;
    logic [10:0] r_rd_code;

    assign w_busy_next = (w_state_next == S_FILL) || (w_state_next == S_SHUFFLE)
`ifdef TILE_SHUFFLE_CHECK_EN
                         || (w_state_next == S_CHECK)
`endif
                         ;

    // Next-state, index and tile-file update logic.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_tile_next  = r_tile;
        w_draw       = r_lfsr[3:0] & draw_mask(r_idx);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FILL;
                    w_idx_next   = 4'd0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_FILL: begin
                w_tile_next[r_idx] = {3'b000, r_idx[3:1]} + 6'd1;
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_SHUFFLE;
                    w_idx_next   = LAST_IDX;
                end else begin
                    w_idx_next = r_idx + 4'd1;
                end
            end
            S_SHUFFLE: begin
                if (w_draw <= r_idx) begin
                    w_tile_next[r_idx]  = r_tile[w_draw];
                    w_tile_next[w_draw] = r_tile[r_idx];
                    if (r_idx == 4'd1) begin
                        w_state_next = SHUFFLE_EXIT;
                        w_idx_next   = 4'd0;
                    end else begin
                        w_idx_next = r_idx - 4'd1;
                    end
                end else begin
                    w_state_next = S_SHUFFLE;
                end
            end
`ifdef TILE_SHUFFLE_CHECK_EN
            S_CHECK: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_DONE;
                end else begin
                    w_idx_next = r_idx + 4'd1;
                end
            end
`endif
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, LFSR, tile file and registered outputs; the read port sees post-update contents.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_lfsr    <= SEED_EFF;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_code <= 11'd0;
            for (int k = 0; k < NUM_TILES; k++) begin
                r_tile[k] <= default_colour(4'(k));
            end
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_lfsr    <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
            r_busy    <= w_busy_next;
            r_done    <= (w_state_next == S_DONE);
            r_tile    <= w_tile_next;
            if (w_busy_next || ({1'b0, rd_idx} >= TILES_5B)) begin
                r_rd_code <= 11'd0;
            end else begin
                r_rd_code <= {4'b0000, w_tile_next[rd_idx], 1'b0};
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_code = r_rd_code;

`ifdef TILE_SHUFFLE_CHECK_EN
    localparam int unsigned NUM_COLOURS = NUM_TILES / 2;

    logic [1:0] r_cnt      [NUM_COLOURS];
    logic [1:0] w_cnt_next [NUM_COLOURS];
    logic       r_bad;
    logic       w_bad_next;
    logic       w_err_now;
    logic       r_err;

    // Per-colour saturating counts; counts are cleared while the board is being filled.
    always_comb begin
        w_cnt_next = r_cnt;
        w_bad_next = r_bad;
        w_err_now  = 1'b0;
        if (r_state == S_FILL) begin
            for (int c = 0; c < NUM_COLOURS; c++) begin
                w_cnt_next[c] = 2'd0;
            end
            w_bad_next = 1'b0;
        end else if (r_state == S_CHECK) begin
            w_bad_next = r_bad || (r_tile[r_idx] == 6'd0) || (r_tile[r_idx] > 6'(NUM_COLOURS));
            for (int c = 0; c < NUM_COLOURS; c++) begin
                if ((r_tile[r_idx] == 6'(c + 1)) && (r_cnt[c] != 2'd3)) begin
                    w_cnt_next[c] = r_cnt[c] + 2'd1;
                end
            end
        end else begin
            w_bad_next = r_bad;
        end
        w_err_now = w_bad_next;
        for (int c = 0; c < NUM_COLOURS; c++) begin
            if (w_cnt_next[c] != 2'd2) begin
                w_err_now = 1'b1;
            end
        end
    end

    // Check counters and the sticky error flag, which lands together with done.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
            for (int c = 0; c < NUM_COLOURS; c++) begin
                r_cnt[c] <= 2'd0;
            end
        end else begin
            r_bad <= w_bad_next;
            r_cnt <= w_cnt_next;
            if ((r_state == S_IDLE) && start) begin
                r_err <= 1'b0;
            end else if ((r_state == S_CHECK) && (w_state_next == S_DONE)) begin
                r_err <= w_err_now;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
